// File: rtl/hdmi_tx_pkg.sv
// Shared constants and types for the HDMI TX link controller: TMDS control tokens,
// video guard-band words, preamble CTL pattern and the link state enum.
package hdmi_tx_pkg;

    localparam int LOOKAHEAD    = 10;
    localparam int PREAMBLE_LEN = 8;

    localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;

    localparam logic [9:0] CTRL_TOKEN [0:3] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam logic [9:0] VID_GB_CH0 = 10'b1011001100;
    localparam logic [9:0] VID_GB_CH1 = 10'b0100110011;
    localparam logic [9:0] VID_GB_CH2 = 10'b1011001100;

    // CTL3..CTL0 during the video preamble: only CTL0 is set
    localparam logic [3:0] PREAMBLE_CTL_VIDEO = 4'b0001;

    typedef enum logic [1:0] {
        RST_HOLD,
        STARTUP,
        RUN
    } link_state_t;

    typedef struct packed {
        logic       de;
        logic       hsync;
        logic       vsync;
        logic [9:0] ch0;
        logic [9:0] ch1;
        logic [9:0] ch2;
    } tap_t;

    function automatic logic [9:0] ctl_token(input logic [1:0] ctl);
        return CTRL_TOKEN[ctl];
    endfunction

endpackage

// File: rtl/hdmi_tx_rst_seq.sv
// Serializer reset sequencer: synchronizes PLL lock, holds the serializers in reset,
// runs the control-token startup period and raises link_ready once the link is in RUN.
module hdmi_tx_rst_seq
    import hdmi_tx_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int STARTUP_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        blank_ok,
    output logic        lock_s,
    output link_state_t state,
    output logic        serdes_rst,
    output logic        link_ready
);

    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int START_W = $clog2(STARTUP_CYCLES + 1);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [START_W-1:0] START_MAX = START_W'(STARTUP_CYCLES);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [RST_W-1:0]       rst_cnt;
    logic [START_W-1:0]     start_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

    // Losing lock in any state drops straight back to RST_HOLD with both counters cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_HOLD;
            rst_cnt    <= '0;
            start_cnt  <= '0;
            serdes_rst <= 1'b1;
            link_ready <= 1'b0;
        end else if (!lock_s) begin
            state      <= RST_HOLD;
            rst_cnt    <= '0;
            start_cnt  <= '0;
            serdes_rst <= 1'b1;
            link_ready <= 1'b0;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= STARTUP;
                        rst_cnt    <= '0;
                        serdes_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                STARTUP: begin
                    if (start_cnt != START_MAX) begin
                        start_cnt <= start_cnt + 1'b1;
                    end else if (blank_ok) begin
                        state      <= RUN;
                        link_ready <= 1'b1;
                    end
                end
                RUN: begin
                    link_ready <= 1'b1;
                end
                default: begin
                    state      <= RST_HOLD;
                    serdes_rst <= 1'b1;
                    link_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hdmi_tx_link_ctrl.sv
// TMDS symbol scheduler: 10-deep lookahead delay line, video preamble/guard-band
// insertion window and the registered per-channel symbol mux feeding the serializers.
module hdmi_tx_link_ctrl
    import hdmi_tx_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int STARTUP_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       paralell_clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       hdmi_mode,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] ch0_enc,
    input  logic [9:0] ch1_enc,
    input  logic [9:0] ch2_enc,
    output logic       serdes_rst,
    output logic [9:0] ch0_sym,
    output logic [9:0] ch1_sym,
    output logic [9:0] ch2_sym,
    output logic       link_ready
);

    localparam logic [3:0] WIN_LAST = 4'(LOOKAHEAD);
    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN);

    tap_t        taps [1:LOOKAHEAD];
    tap_t        out_tap;
    logic        taps_zero;
    logic        arm;
    logic        blank_ok;
    logic        lock_s;
    link_state_t state;
    logic [3:0]  win_cnt;
    logic [3:0]  win_pos;
    logic [9:0]  nxt_ch0;
    logic [9:0]  nxt_ch1;
    logic [9:0]  nxt_ch2;

    hdmi_tx_rst_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .STARTUP_CYCLES(STARTUP_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rst_seq (
        .clk       (paralell_clk),
        .rst_n     (reset_n),
        .pll_locked(pll_locked),
        .blank_ok  (blank_ok),
        .lock_s    (lock_s),
        .state     (state),
        .serdes_rst(serdes_rst),
        .link_ready(link_ready)
    );

    always_ff @(posedge paralell_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= LOOKAHEAD; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[1] <= {de_in, hsync_in, vsync_in, ch0_enc, ch1_enc, ch2_enc};
            for (int i = 2; i <= LOOKAHEAD; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign out_tap = taps[LOOKAHEAD];

    always_comb begin
        taps_zero = 1'b1;
        for (int i = 1; i <= LOOKAHEAD; i++) begin
            if (taps[i].de) begin
                taps_zero = 1'b0;
            end
        end
    end

    // A DE rise with a fully blank lookahead means the next 10 output slots are free
    // for preamble + guard band; position 1 of that window is the arming cycle itself.
    assign arm     = hdmi_mode && de_in && !taps[1].de && taps_zero;
    assign win_pos = arm ? 4'd1 : win_cnt;

    // Also requiring de_in low keeps RUN entry from landing on an arming edge,
    // so the first window seen in RUN is always complete.
    assign blank_ok = taps_zero && !de_in;

    always_ff @(posedge paralell_clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt <= 4'd0;
        end else if (!lock_s) begin
            win_cnt <= 4'd0;
        end else if (arm) begin
            win_cnt <= 4'd2;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt <= 4'd0;
        end else if (win_cnt != 4'd0) begin
            win_cnt <= win_cnt + 4'd1;
        end
    end

    always_comb begin
        nxt_ch0 = ctl_token({out_tap.vsync, out_tap.hsync});
        nxt_ch1 = CTL_TOKEN_00;
        nxt_ch2 = CTL_TOKEN_00;
        if (!lock_s || state == RST_HOLD) begin
            nxt_ch0 = CTL_TOKEN_00;
        end else if (state == RUN) begin
            if (out_tap.de) begin
                nxt_ch0 = out_tap.ch0;
                nxt_ch1 = out_tap.ch1;
                nxt_ch2 = out_tap.ch2;
            end else if (win_pos != 4'd0 && win_pos <= PRE_LAST) begin
                nxt_ch1 = ctl_token(PREAMBLE_CTL_VIDEO[1:0]);
                nxt_ch2 = ctl_token(PREAMBLE_CTL_VIDEO[3:2]);
            end else if (win_pos > PRE_LAST) begin
                nxt_ch0 = VID_GB_CH0;
                nxt_ch1 = VID_GB_CH1;
                nxt_ch2 = VID_GB_CH2;
            end
        end
    end

    always_ff @(posedge paralell_clk or negedge reset_n) begin
        if (!reset_n) begin
            ch0_sym <= CTL_TOKEN_00;
            ch1_sym <= CTL_TOKEN_00;
            ch2_sym <= CTL_TOKEN_00;
        end else begin
            ch0_sym <= nxt_ch0;
            ch1_sym <= nxt_ch1;
            ch2_sym <= nxt_ch2;
        end
    end

endmodule
